segre_mem_stage: RTL and testbench
==================================

Name: segre_mem_stage

Overview:
- MEM stage, directly downstream of the TL stage; consumes its registered outputs and drives the WB stage.
- Owns the data-cache data array: accepts MMU lane fills, performs load extraction (lane or store-buffer hit) and store-buffer flush writes.
- Queues write-through stores toward memory and registers results for writeback with 1-cycle latency.

Parameters:
WORD_SIZE, 32, data/address word width
REG_SIZE, 5, register index width
DCACHE_LANES, 4, number of cache lanes
DCACHE_LANE_SIZE, 128, bits per lane
DCACHE_INDEX_SIZE, 2, lane index width (log2 DCACHE_LANES)
WT_DEPTH, 2, write-through queue entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, synchronous, active-low
alu_res_i  in  WORD_SIZE  ALU result / load address
rf_we_i  in  1  register write enable
rf_waddr_i  in  REG_SIZE  destination register
addr_index_i  in  DCACHE_INDEX_SIZE  lane holding the access
memop_rd_i  in  1  load
memop_wr_i  in  1  store-buffer flush write
memop_sign_ext_i  in  1  sign-extend load
memop_type_i  in  memop_data_type_e  load size (BYTE/HALF/WORD)
memop_type_flush_i  in  memop_data_type_e  flush size
tkbr_i  in  1  taken branch
new_pc_i  in  WORD_SIZE  branch target
sb_hit_i  in  1  load served by store buffer
sb_data_load_i  in  WORD_SIZE  store-buffer load data, LSB-aligned
sb_data_flush_i  in  WORD_SIZE  flush data, LSB-aligned
sb_addr_i  in  WORD_SIZE  flush address
mmu_data_rdy_i  in  1  fill valid
mmu_data_i  in  DCACHE_LANE_SIZE  fill lane
mmu_lru_index_i  in  DCACHE_INDEX_SIZE  fill lane index
wt_valid_o  out  1  write-through request valid
wt_ready_i  in  1  memory accepts request
wt_addr_o  out  WORD_SIZE  write-through address
wt_data_o  out  WORD_SIZE  write-through data
wt_type_o  out  memop_data_type_e  write-through size
rf_we_o  out  1  WB write enable
rf_waddr_o  out  REG_SIZE  WB destination
rf_wdata_o  out  WORD_SIZE  WB data
tkbr_o  out  1  taken branch to fetch
new_pc_o  out  WORD_SIZE  branch target
pipeline_hazard_o  out  1  stall request to upstream

Behaviour:
- Reset (rsn_i low at clk edge): all array lanes 0; queue emptied (wr/rd pointers 0, count 0); rf_we_o, rf_waddr_o, rf_wdata_o, tkbr_o, new_pc_o, wt_valid_o = 0. Fills, stores and dequeues in a reset cycle are ignored.
- Fill: mmu_data_rdy_i writes the full mmu_data_i into lane mmu_lru_index_i at the clock edge.
- Store: memop_wr_i & !hazard merges sb_data_flush_i into lane addr_index_i.
  - Offset: BYTE at sb_addr_i[3:0]; HALF at {sb_addr_i[3:1],0}; WORD at {sb_addr_i[3:2],00}. Low bits are dropped, never wrapped.
  - Same-cycle fill to the same lane: fill applied first, store bytes overwrite it.
  - The same store enqueues {sb_addr_i, sb_data_flush_i, memop_type_flush_i} into the write-through queue.
- Load: memop_rd_i.
  - Source: sb_data_load_i if sb_hit_i, else the lane addr_index_i extracted at alu_res_i offset, same alignment rules as stores.
  - Fill bypass: same-cycle fill to addr_index_i bypasses mmu_data_i.
  - Width: BYTE/HALF zero- or sign-extended per memop_sign_ext_i; WORD passed unchanged.
- Non-memory ops: rf_wdata_o = alu_res_i.
- Output register (1 cycle), when !hazard: rf_we_o, rf_waddr_o, tkbr_o, new_pc_o copied from inputs; rf_wdata_o from the load path or ALU.
- Queue: circular FIFO, WT_DEPTH entries; head drives wt_*_o; wt_valid_o = count!=0.
  - Dequeue on wt_valid_o & wt_ready_i.
  - Simultaneous enqueue+dequeue keeps count unchanged.
- Hazard: pipeline_hazard_o = memop_wr_i & (count==WT_DEPTH), combinational. Full is conservative: no same-cycle dequeue credit.
  - While asserted: no array write, no enqueue, rf_we_o=0, tkbr_o=0 next cycle.
  - Upstream holds inputs stable until the hazard drops.
  - Fills still apply during a hazard.
- A load and a store in the same cycle is illegal (upstream guarantees); store wins if violated.

Optional Feature:
SEGRE_MEM_PERF_EN
- Defined: adds outputs perf_loads_o, perf_stores_o, perf_stall_o (32-bit each).
  - They count accepted loads, accepted stores and hazard cycles.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Fill lane 1 with 0x0F0E0D0C_0B0A0908_07060504_03020100, then load BYTE signed from alu_res=0x..05, index 1 -> rf_wdata_o=0x00000005 one cycle later. Load HALF signed from 0x..0E after flushing 0x8000 there -> 0xFFFF8000.
- Flush WORD 0xDEADBEEF to sb_addr 0x1008, lane 2; later load WORD from 0x100B (index 2) -> 0xDEADBEEF. wt_valid_o=1 with addr 0x1008, data 0xDEADBEEF, type WORD.
- wt_ready_i=0, three consecutive flushes -> first two enqueue. Third raises pipeline_hazard_o, rf_we_o=0. Raising wt_ready_i for one cycle -> hazard drops next cycle, third store enqueued, order preserved.
- Same-cycle fill of lane 0 (all 0x11) and BYTE store 0xAB at offset 3 of lane 0 -> lane 0 reads 0x11 everywhere except byte 3 = 0xAB.
- sb_hit_i=1, sb_data_load_i=0x000000FF, BYTE signed load -> 0xFFFFFFFF; lane data ignored.
- Reset asserted with 2 queued entries and a fill pending -> next cycle wt_valid_o=0, all outputs 0, lanes read 0.

Source files
------------

// File: rtl/segre_mem_pkg.sv
// Shared types for the segre MEM stage: memory-operation access size.
package segre_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

endpackage

// File: rtl/segre_mem_stage.sv
// MEM stage: data-cache data array, load extraction, write-through store queue, WB register.
// Optional SEGRE_MEM_PERF_EN adds saturating load/store/stall counters.
module segre_mem_stage
    import segre_mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE         = 32,
    parameter int unsigned REG_SIZE          = 5,
    parameter int unsigned DCACHE_LANES      = 4,
    parameter int unsigned DCACHE_LANE_SIZE  = 128,
    parameter int unsigned DCACHE_INDEX_SIZE = 2,
    parameter int unsigned WT_DEPTH          = 2
) (
    input  logic                         clk_i,
    input  logic                         rsn_i,
    input  logic [WORD_SIZE-1:0]         alu_res_i,
    input  logic                         rf_we_i,
    input  logic [REG_SIZE-1:0]          rf_waddr_i,
    input  logic [DCACHE_INDEX_SIZE-1:0] addr_index_i,
    input  logic                         memop_rd_i,
    input  logic                         memop_wr_i,
    input  logic                         memop_sign_ext_i,
    input  memop_data_type_e             memop_type_i,
    input  memop_data_type_e             memop_type_flush_i,
    input  logic                         tkbr_i,
    input  logic [WORD_SIZE-1:0]         new_pc_i,
    input  logic                         sb_hit_i,
    input  logic [WORD_SIZE-1:0]         sb_data_load_i,
    input  logic [WORD_SIZE-1:0]         sb_data_flush_i,
    input  logic [WORD_SIZE-1:0]         sb_addr_i,
    input  logic                         mmu_data_rdy_i,
    input  logic [DCACHE_LANE_SIZE-1:0]  mmu_data_i,
    input  logic [DCACHE_INDEX_SIZE-1:0] mmu_lru_index_i,
    output logic                         wt_valid_o,
    input  logic                         wt_ready_i,
    output logic [WORD_SIZE-1:0]         wt_addr_o,
    output logic [WORD_SIZE-1:0]         wt_data_o,
    output memop_data_type_e             wt_type_o,
    output logic                         rf_we_o,
    output logic [REG_SIZE-1:0]          rf_waddr_o,
    output logic [WORD_SIZE-1:0]         rf_wdata_o,
    output logic                         tkbr_o,
    output logic [WORD_SIZE-1:0]         new_pc_o,
    output logic                         pipeline_hazard_o
`ifdef SEGRE_MEM_PERF_EN
   ,output logic [31:0]                  perf_loads_o,
    output logic [31:0]                  perf_stores_o,
    output logic [31:0]                  perf_stall_o
`endif
);

    localparam int unsigned OFF_W  = $clog2(DCACHE_LANE_SIZE / 8);
    localparam int unsigned WBYTES = WORD_SIZE / 8;
    localparam int unsigned PTR_W  = $clog2(WT_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    // Drop the low offset bits so every access stays naturally aligned inside the lane.
    function automatic logic [OFF_W-1:0] align_off(input logic [OFF_W-1:0] a,
                                                   input memop_data_type_e t);
        case (t)
            HALF:    align_off = {a[OFF_W-1:1], 1'b0};
            WORD:    align_off = {a[OFF_W-1:2], 2'b00};
            default: align_off = a;
        endcase
    endfunction

    function automatic int unsigned size_bytes(input memop_data_type_e t);
        case (t)
            BYTE:    size_bytes = 1;
            HALF:    size_bytes = 2;
            default: size_bytes = WBYTES;
        endcase
    endfunction

    logic [DCACHE_LANE_SIZE-1:0] lane_q [DCACHE_LANES];
    logic [DCACHE_LANE_SIZE-1:0] lane_d [DCACHE_LANES];

    logic [WORD_SIZE-1:0]  wt_addr_q [WT_DEPTH];
    logic [WORD_SIZE-1:0]  wt_data_q [WT_DEPTH];
    memop_data_type_e      wt_type_q [WT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  rf_we_q, tkbr_q;
    logic [REG_SIZE-1:0]   rf_waddr_q;
    logic [WORD_SIZE-1:0]  rf_wdata_q, new_pc_q;

    logic                  hazard_c, st_en_c, enq_c, deq_c, ld_sel_c;
    logic [OFF_W-1:0]      st_off_c, ld_off_c;
    logic [DCACHE_LANE_SIZE-1:0] ld_lane_c;
    logic [WORD_SIZE-1:0]  ld_raw_c, ld_src_c, ld_ext_c, wb_data_c;

    // Full is judged on the registered count only; a same-cycle dequeue gives no credit.
    assign hazard_c = memop_wr_i & (cnt_q == CNT_W'(WT_DEPTH));
    assign st_en_c  = memop_wr_i & ~hazard_c;
    assign enq_c    = st_en_c;
    assign deq_c    = (cnt_q != '0) & wt_ready_i;
    assign st_off_c = align_off(sb_addr_i[OFF_W-1:0], memop_type_flush_i);
    assign ld_off_c = align_off(alu_res_i[OFF_W-1:0], memop_type_i);
    assign ld_sel_c = memop_rd_i & ~memop_wr_i;

    // Next array contents: fill first, then store bytes on top of it.
    always_comb begin
        logic [OFF_W-1:0] bi;
        lane_d = lane_q;
        bi     = '0;
        if (mmu_data_rdy_i) begin
            lane_d[mmu_lru_index_i] = mmu_data_i;
        end
        if (st_en_c) begin
            for (int unsigned b = 0; b < WBYTES; b++) begin
                bi = st_off_c + OFF_W'(b);
                if (b < size_bytes(memop_type_flush_i)) begin
                    lane_d[addr_index_i][{bi, 3'b000} +: 8] = sb_data_flush_i[b*8 +: 8];
                end
            end
        end
    end

    // Load path with same-cycle fill bypass and size/sign handling.
    always_comb begin
        logic [OFF_W-1:0] bi;
        bi        = '0;
        ld_raw_c  = '0;
        ld_lane_c = (mmu_data_rdy_i && (mmu_lru_index_i == addr_index_i))
                    ? mmu_data_i : lane_q[addr_index_i];
        for (int unsigned b = 0; b < WBYTES; b++) begin
            bi = ld_off_c + OFF_W'(b);
            ld_raw_c[b*8 +: 8] = ld_lane_c[{bi, 3'b000} +: 8];
        end
        ld_src_c = sb_hit_i ? sb_data_load_i : ld_raw_c;
        case (memop_type_i)
            BYTE:    ld_ext_c = {{(WORD_SIZE-8){memop_sign_ext_i & ld_src_c[7]}}, ld_src_c[7:0]};
            HALF:    ld_ext_c = {{(WORD_SIZE-16){memop_sign_ext_i & ld_src_c[15]}}, ld_src_c[15:0]};
            default: ld_ext_c = ld_src_c;
        endcase
        wb_data_c = ld_sel_c ? ld_ext_c : alu_res_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            lane_q     <= '{default: '0};
            wt_addr_q  <= '{default: '0};
            wt_data_q  <= '{default: '0};
            wt_type_q  <= '{default: BYTE};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            tkbr_q     <= 1'b0;
            new_pc_q   <= '0;
        end else begin
            lane_q <= lane_d;
            if (!hazard_c) begin
                rf_we_q    <= rf_we_i;
                rf_waddr_q <= rf_waddr_i;
                rf_wdata_q <= wb_data_c;
                tkbr_q     <= tkbr_i;
                new_pc_q   <= new_pc_i;
            end else begin
                rf_we_q <= 1'b0;
                tkbr_q  <= 1'b0;
            end
            if (enq_c) begin
                wt_addr_q[wr_ptr_q] <= sb_addr_i;
                wt_data_q[wr_ptr_q] <= sb_data_flush_i;
                wt_type_q[wr_ptr_q] <= memop_type_flush_i;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign wt_valid_o        = (cnt_q != '0);
    assign wt_addr_o         = wt_addr_q[rd_ptr_q];
    assign wt_data_o         = wt_data_q[rd_ptr_q];
    assign wt_type_o         = wt_type_q[rd_ptr_q];
    assign rf_we_o           = rf_we_q;
    assign rf_waddr_o        = rf_waddr_q;
    assign rf_wdata_o        = rf_wdata_q;
    assign tkbr_o            = tkbr_q;
    assign new_pc_o          = new_pc_q;
    assign pipeline_hazard_o = hazard_c;

`ifdef SEGRE_MEM_PERF_EN
    logic [31:0] perf_loads_q, perf_stores_q, perf_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (ld_sel_c && (perf_loads_q != '1))  perf_loads_q  <= perf_loads_q + 32'd1;
            if (st_en_c && (perf_stores_q != '1))  perf_stores_q <= perf_stores_q + 32'd1;
            if (hazard_c && (perf_stall_q != '1))  perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_loads_o  = perf_loads_q;
    assign perf_stores_o = perf_stores_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_segre_mem_stage.sv
// Directed bench for segre_mem_stage: fills, loads, stores, write-through queue, hazard, reset.
module tb_segre_mem_stage;
    import segre_mem_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rsn_i;
    logic [31:0]          alu_res_i;
    logic                 rf_we_i;
    logic [4:0]           rf_waddr_i;
    logic [1:0]           addr_index_i;
    logic                 memop_rd_i, memop_wr_i, memop_sign_ext_i;
    memop_data_type_e     memop_type_i, memop_type_flush_i;
    logic                 tkbr_i;
    logic [31:0]          new_pc_i;
    logic                 sb_hit_i;
    logic [31:0]          sb_data_load_i, sb_data_flush_i, sb_addr_i;
    logic                 mmu_data_rdy_i;
    logic [127:0]         mmu_data_i;
    logic [1:0]           mmu_lru_index_i;
    logic                 wt_valid_o, wt_ready_i;
    logic [31:0]          wt_addr_o, wt_data_o;
    memop_data_type_e     wt_type_o;
    logic                 rf_we_o;
    logic [4:0]           rf_waddr_o;
    logic [31:0]          rf_wdata_o;
    logic                 tkbr_o;
    logic [31:0]          new_pc_o;
    logic                 pipeline_hazard_o;

    int n_pass  = 0;
    int n_total = 0;

    segre_mem_stage dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .alu_res_i(alu_res_i), .rf_we_i(rf_we_i),
        .rf_waddr_i(rf_waddr_i), .addr_index_i(addr_index_i), .memop_rd_i(memop_rd_i),
        .memop_wr_i(memop_wr_i), .memop_sign_ext_i(memop_sign_ext_i),
        .memop_type_i(memop_type_i), .memop_type_flush_i(memop_type_flush_i),
        .tkbr_i(tkbr_i), .new_pc_i(new_pc_i), .sb_hit_i(sb_hit_i),
        .sb_data_load_i(sb_data_load_i), .sb_data_flush_i(sb_data_flush_i),
        .sb_addr_i(sb_addr_i), .mmu_data_rdy_i(mmu_data_rdy_i), .mmu_data_i(mmu_data_i),
        .mmu_lru_index_i(mmu_lru_index_i), .wt_valid_o(wt_valid_o), .wt_ready_i(wt_ready_i),
        .wt_addr_o(wt_addr_o), .wt_data_o(wt_data_o), .wt_type_o(wt_type_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .tkbr_o(tkbr_o), .new_pc_o(new_pc_o), .pipeline_hazard_o(pipeline_hazard_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        alu_res_i = '0; rf_we_i = 1'b0; rf_waddr_i = '0; addr_index_i = '0;
        memop_rd_i = 1'b0; memop_wr_i = 1'b0; memop_sign_ext_i = 1'b0;
        memop_type_i = BYTE; memop_type_flush_i = BYTE; tkbr_i = 1'b0; new_pc_i = '0;
        sb_hit_i = 1'b0; sb_data_load_i = '0; sb_data_flush_i = '0; sb_addr_i = '0;
        mmu_data_rdy_i = 1'b0; mmu_data_i = '0; mmu_lru_index_i = '0;
    endtask

    task automatic do_fill(input logic [1:0] idx, input logic [127:0] data);
        mmu_data_rdy_i = 1'b1; mmu_lru_index_i = idx; mmu_data_i = data;
        step();
        idle();
    endtask

    task automatic do_store(input memop_data_type_e t, input logic [31:0] data,
                            input logic [31:0] addr, input logic [1:0] idx);
        memop_wr_i = 1'b1; memop_type_flush_i = t; sb_data_flush_i = data;
        sb_addr_i = addr; addr_index_i = idx;
        step();
        idle();
    endtask

    task automatic do_load(input string tag, input memop_data_type_e t, input logic sx,
                           input logic [31:0] addr, input logic [1:0] idx,
                           input logic [31:0] exp);
        memop_rd_i = 1'b1; memop_type_i = t; memop_sign_ext_i = sx;
        alu_res_i = addr; addr_index_i = idx; rf_we_i = 1'b1; rf_waddr_i = 5'd3;
        step();
        check(tag, rf_wdata_o, exp);
        idle();
    endtask

    initial begin
        rsn_i = 1'b0; wt_ready_i = 1'b1;
        idle();
        step(); step();
        check("rst_rf_we",  32'(rf_we_o), 32'd0);
        check("rst_wdata",  rf_wdata_o, 32'd0);
        check("rst_tkbr",   32'(tkbr_o), 32'd0);
        check("rst_wt_vld", 32'(wt_valid_o), 32'd0);
        rsn_i = 1'b1;

        // Fill + extraction
        do_fill(2'd1, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        do_load("ld_b_s_05", BYTE, 1'b1, 32'h0000_0105, 2'd1, 32'h0000_0005);
        check("ld_rf_we", 32'(rf_we_o), 32'd1);
        check("ld_waddr", 32'(rf_waddr_o), 32'd3);
        do_load("ld_h_unal", HALF, 1'b0, 32'h0000_0105, 2'd1, 32'h0000_0504);

        // Fill bypass into lane 3
        mmu_data_rdy_i = 1'b1; mmu_lru_index_i = 2'd3; mmu_data_i = {4{32'h89ABCDEF}};
        do_load("ld_bypass", WORD, 1'b0, 32'h0000_0004, 2'd3, 32'h89AB_CDEF);

        // HALF flush then signed/unsigned reads around it
        do_store(HALF, 32'h0000_8000, 32'h0000_020E, 2'd1);
        check("wt_vld_h",  32'(wt_valid_o), 32'd1);
        check("wt_addr_h", wt_addr_o, 32'h0000_020E);
        check("wt_type_h", 32'(wt_type_o), 32'(HALF));
        do_load("ld_h_s_8000", HALF, 1'b1, 32'h0000_020E, 2'd1, 32'hFFFF_8000);
        do_load("ld_h_u_8000", HALF, 1'b0, 32'h0000_020F, 2'd1, 32'h0000_8000);
        do_load("ld_w_0c",     WORD, 1'b0, 32'h0000_020C, 2'd1, 32'h8000_0D0C);
        do_load("ld_b_s_0f",   BYTE, 1'b1, 32'h0000_020F, 2'd1, 32'hFFFF_FF80);
        do_load("ld_b_u_0f",   BYTE, 1'b0, 32'h0000_020F, 2'd1, 32'h0000_0080);

        // WORD flush + write-through
        do_store(WORD, 32'hDEAD_BEEF, 32'h0000_1008, 2'd2);
        check("wt_vld_w",  32'(wt_valid_o), 32'd1);
        check("wt_addr_w", wt_addr_o, 32'h0000_1008);
        check("wt_data_w", wt_data_o, 32'hDEAD_BEEF);
        check("wt_type_w", 32'(wt_type_o), 32'(WORD));
        do_load("ld_w_100b", WORD, 1'b0, 32'h0000_100B, 2'd2, 32'hDEAD_BEEF);
        check("wt_drained", 32'(wt_valid_o), 32'd0);

        // Queue full and hazard
        wt_ready_i = 1'b0;
        do_store(BYTE, 32'h0000_0011, 32'h0000_2000, 2'd3);
        do_store(BYTE, 32'h0000_0022, 32'h0000_2001, 2'd3);
        memop_wr_i = 1'b1; memop_type_flush_i = BYTE; sb_data_flush_i = 32'h0000_0033;
        sb_addr_i = 32'h0000_2002; addr_index_i = 2'd3;
        rf_we_i = 1'b1; rf_waddr_i = 5'd7; tkbr_i = 1'b1; new_pc_i = 32'h0000_4000;
        #1;
        check("hz_full", 32'(pipeline_hazard_o), 32'd1);
        step();
        check("hz_rf_we",  32'(rf_we_o), 32'd0);
        check("hz_tkbr",   32'(tkbr_o), 32'd0);
        check("hz_head_a", wt_addr_o, 32'h0000_2000);
        wt_ready_i = 1'b1;
        #1;
        check("hz_no_credit", 32'(pipeline_hazard_o), 32'd1);
        step();
        wt_ready_i = 1'b0;
        #1;
        check("hz_drop",   32'(pipeline_hazard_o), 32'd0);
        check("hz_head_b", wt_addr_o, 32'h0000_2001);
        step();
        check("acc_rf_we",  32'(rf_we_o), 32'd1);
        check("acc_waddr",  32'(rf_waddr_o), 32'd7);
        check("acc_tkbr",   32'(tkbr_o), 32'd1);
        check("acc_new_pc", new_pc_o, 32'h0000_4000);
        idle();
        wt_ready_i = 1'b1;
        #1;
        check("ord_b", wt_addr_o, 32'h0000_2001);
        step();
        check("ord_c_addr", wt_addr_o, 32'h0000_2002);
        check("ord_c_data", wt_data_o, 32'h0000_0033);
        step();
        check("ord_empty", 32'(wt_valid_o), 32'd0);
        do_load("ld_lane3", WORD, 1'b0, 32'h0000_2000, 2'd3, 32'h8933_2211);

        // Same-cycle fill and store on lane 0
        mmu_data_rdy_i = 1'b1; mmu_lru_index_i = 2'd0; mmu_data_i = {16{8'h11}};
        do_store(BYTE, 32'h0000_00AB, 32'h0000_0003, 2'd0);
        do_load("fs_w0", WORD, 1'b0, 32'h0000_0000, 2'd0, 32'hAB11_1111);
        do_load("fs_w3", WORD, 1'b0, 32'h0000_000C, 2'd0, 32'h1111_1111);

        // Store-buffer hit overrides lane data
        sb_hit_i = 1'b1; sb_data_load_i = 32'h0000_00FF;
        do_load("sb_hit", BYTE, 1'b1, 32'h0000_0105, 2'd1, 32'hFFFF_FFFF);

        // Non-memory op passes ALU result
        alu_res_i = 32'h1234_5678; tkbr_i = 1'b1; new_pc_i = 32'h0000_0ABC;
        step();
        check("alu_pass", rf_wdata_o, 32'h1234_5678);
        check("br_pc",    new_pc_o, 32'h0000_0ABC);
        idle();

        // Reset with queued entries and a pending fill
        wt_ready_i = 1'b0;
        do_store(WORD, 32'h0000_0001, 32'h0000_0000, 2'd1);
        do_store(WORD, 32'h0000_0002, 32'h0000_0004, 2'd1);
        check("pre_rst_vld", 32'(wt_valid_o), 32'd1);
        rsn_i = 1'b0;
        mmu_data_rdy_i = 1'b1; mmu_lru_index_i = 2'd2; mmu_data_i = '1;
        rf_we_i = 1'b1; tkbr_i = 1'b1; new_pc_i = 32'h0000_0100; alu_res_i = 32'h0000_0055;
        step();
        check("rst2_wt_vld", 32'(wt_valid_o), 32'd0);
        check("rst2_rf_we",  32'(rf_we_o), 32'd0);
        check("rst2_tkbr",   32'(tkbr_o), 32'd0);
        check("rst2_pc",     new_pc_o, 32'd0);
        check("rst2_wdata",  rf_wdata_o, 32'd0);
        rsn_i = 1'b1;
        idle();
        do_load("rst2_lane1", WORD, 1'b0, 32'h0000_0000, 2'd1, 32'd0);
        do_load("rst2_lane2", WORD, 1'b0, 32'h0000_0000, 2'd2, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
